// File: rtl/uns_addsub_mw.sv
`default_nettype none
// ============================================================================
//  Module      : uns_addsub_mw
//  Description : Multi-word unsigned add/subtract engine. Operands stream in
//                LSW first, a registered carry ripples one word per cycle,
//                and the result streams out over valid/ready.
//                Optional saturation: define UNS_ADDSUB_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uns_addsub_mw #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              sub,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              cout,
    output logic              busy,
    output logic              done
`ifdef UNS_ADDSUB_SAT_EN
    ,
    output logic              sat
`endif
);

    localparam int c_cnt_w = $clog2(NUM_WORDS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_WORDS - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CALC   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 sub_q, sub_d;
    logic                 carry_q, carry_d;
    logic                 cout_q, cout_d;
    logic                 done_q, done_d;

    // Operand buffers carry no reset; the A buffer doubles as the result store.
    logic [WORD_W-1:0]    a_buf [NUM_WORDS];
    logic [WORD_W-1:0]    b_buf [NUM_WORDS];

    logic                 a_we, b_we;
    logic [WORD_W-1:0]    a_wdata;
    logic [WORD_W-1:0]    b_x;
    logic [WORD_W:0]      sum;
    logic                 last_w;

    assign b_x    = sub_q ? ~b_buf[cnt_q] : b_buf[cnt_q];
    assign sum    = {1'b0, a_buf[cnt_q]} + {1'b0, b_x} + {{WORD_W{1'b0}}, carry_q};
    assign last_w = (cnt_q == c_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        a_wdata = din;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                    sub_d   = sub;
                    cout_d  = 1'b0;
                end
            end
            S_LOAD_A: begin
                if (din_valid) begin
                    a_we = 1'b1;
                    if (last_w) begin
                        state_d = S_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end
            S_LOAD_B: begin
                if (din_valid) begin
                    b_we = 1'b1;
                    if (last_w) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        // Subtraction is A + ~B + 1, so the chain seeds with sub.
                        carry_d = sub_q;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end
            S_CALC: begin
                a_we    = 1'b1;
                a_wdata = sum[WORD_W-1:0];
                carry_d = sum[WORD_W];
                if (last_w) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                    // Carry-out of A + ~B + 1 is the inverse of the borrow.
                    cout_d  = sub_q ^ sum[WORD_W];
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_OUT: begin
                if (dout_ready) begin
                    if (last_w) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) a_buf[cnt_q] <= a_wdata;
        if (b_we) b_buf[cnt_q] <= din;
    end

    assign din_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign dout_valid = (state_q == S_OUT);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign cout       = cout_q;

`ifdef UNS_ADDSUB_SAT_EN
    logic sat_q, sat_d;

    assign sat_d = (state_d == S_OUT) ? cout_d : 1'b0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign sat  = sat_q;
    // Overflow clamps to all ones, underflow to zero.
    assign dout = (state_q == S_OUT) ? (sat_q ? (sub_q ? '0 : '1) : a_buf[cnt_q]) : '0;
`else
    assign dout = (state_q == S_OUT) ? a_buf[cnt_q] : '0;
`endif

endmodule
`default_nettype wire
